// File: rtl/instruction_split_queue.sv
// instruction_split_queue
//   Small FIFO that splits each accepted instruction word into four
//   MSB-first fields (opcode, writeReg, readReg1, readReg2). The split
//   happens at enqueue time, so the head entry's outputs come straight from
//   registered state.
//
// Ports
//   CLK, RESET (async, active high), FLUSH (sync clear, beats push/pop)
//   in_instr/in_valid/in_ready    : enqueue side, push on in_valid && in_ready
//   out_valid/out_ready           : dequeue side, pop on out_valid && out_ready
//   opcode/writeReg/readReg1/readReg2 : head entry fields (0 when empty)
//   immediate : readReg2 sign- or zero-extended to IMM_W (0 when empty)
//   illegal   : head opcode >= NUM_OPCODES (0 when empty)
//   count     : number of queued entries
module instruction_split_queue #(
  parameter int INSTR_W     = 32,
  parameter int FIELD_W     = INSTR_W / 4,
  parameter int DEPTH       = 4,
  parameter int IMM_W       = 32,
  parameter int SIGN_EXT    = 1,
  parameter int NUM_OPCODES = 12
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FLUSH,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIELD_W-1:0]         opcode,
  output logic [FIELD_W-1:0]         writeReg,
  output logic [FIELD_W-1:0]         readReg1,
  output logic [FIELD_W-1:0]         readReg2,
  output logic [IMM_W-1:0]           immediate,
  output logic                       illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One extra bit so every possible opcode value, and NUM_OPCODES itself,
  // compares without truncation.
  localparam logic [FIELD_W:0] NUM_OPC = (FIELD_W + 1)'(NUM_OPCODES);

  typedef struct packed {
    logic               ill;
    logic [FIELD_W-1:0] op;
    logic [FIELD_W-1:0] wr;
    logic [FIELD_W-1:0] r1;
    logic [FIELD_W-1:0] r2;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             in_entry, head;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  logic [IMM_W-1:0]   imm_raw;

  // Split (and legality decode) at enqueue so the head needs no decode logic.
  always_comb begin
    in_entry     = '0;
    in_entry.op  = in_instr[INSTR_W-1 -: FIELD_W];
    in_entry.wr  = in_instr[INSTR_W-1-FIELD_W -: FIELD_W];
    in_entry.r1  = in_instr[INSTR_W-1-2*FIELD_W -: FIELD_W];
    in_entry.r2  = in_instr[FIELD_W-1:0];
    in_entry.ill = ({1'b0, in_entry.op} >= NUM_OPC);
  end

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are PTR_W bits wide with DEPTH a power of two, so the
      // increment wraps modulo DEPTH on its own.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers
  // them, and count_q clears asynchronously.
  always_ff @(posedge CLK) begin
    if (push && !FLUSH) mem_q[wr_ptr_q] <= in_entry;
  end

  assign head = mem_q[rd_ptr_q];

  generate
    if (IMM_W > FIELD_W) begin : g_ext
      logic ext_bit;
      assign ext_bit = (SIGN_EXT != 0) && head.r2[FIELD_W-1];
      assign imm_raw = {{(IMM_W-FIELD_W){ext_bit}}, head.r2};
    end else begin : g_noext
      assign imm_raw = head.r2;
    end
  endgenerate

  // Gate on out_valid so an empty queue (including during RESET) shows zeros.
  assign opcode    = out_valid ? head.op : '0;
  assign writeReg  = out_valid ? head.wr : '0;
  assign readReg1  = out_valid ? head.r1 : '0;
  assign readReg2  = out_valid ? head.r2 : '0;
  assign immediate = out_valid ? imm_raw : '0;
  assign illegal   = out_valid && head.ill;
  assign count     = count_q;

endmodule

// File: tb/tb_instruction_split_queue.sv
module tb_instruction_split_queue;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH, in_valid, out_ready;
  logic [31:0] in_instr;
  logic        in_ready, out_valid, illegal;
  logic [7:0]  opcode, writeReg, readReg1, readReg2;
  logic [31:0] immediate;
  logic [2:0]  count;

  // Zero-extending instance sharing all inputs.
  logic        z_in_ready, z_out_valid, z_illegal;
  logic [7:0]  z_opcode, z_writeReg, z_readReg1, z_readReg2;
  logic [31:0] z_immediate;
  logic [2:0]  z_count;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  instruction_split_queue #(.SIGN_EXT(1)) u_dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .in_instr(in_instr),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .writeReg(writeReg),
    .readReg1(readReg1), .readReg2(readReg2), .immediate(immediate),
    .illegal(illegal), .count(count));

  instruction_split_queue #(.SIGN_EXT(0)) u_zx (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .in_instr(in_instr),
    .in_valid(in_valid), .in_ready(z_in_ready), .out_valid(z_out_valid),
    .out_ready(out_ready), .opcode(z_opcode), .writeReg(z_writeReg),
    .readReg1(z_readReg1), .readReg2(z_readReg2), .immediate(z_immediate),
    .illegal(z_illegal), .count(z_count));

  typedef struct {
    logic        vin;
    logic [31:0] instr;
    logic        ordy;
    logic        flush;
    logic        ov;
    logic        ir;
    logic [2:0]  cnt;
    logic [31:0] head;
    logic [31:0] imm;
    logic [31:0] imm0;
    logic        ill;
  } vec_t;

  vec_t tv[$];

  // Expected outputs follow from the head word alone: fields MSB-first,
  // immediate = low byte extended, illegal when opcode >= 12.
  function automatic vec_t mk(logic vin, logic [31:0] instr, logic ordy,
                              logic fl, logic [2:0] cnt, logic [31:0] head);
    vec_t v;
    v.vin = vin; v.instr = instr; v.ordy = ordy; v.flush = fl;
    v.cnt  = cnt;
    v.ov   = (cnt != 0);
    v.ir   = (cnt < 3'd4);
    v.head = v.ov ? head : 32'h0;
    v.imm  = {{24{v.head[7]}}, v.head[7:0]};
    v.imm0 = {24'h0, v.head[7:0]};
    v.ill  = v.ov && (v.head[31:24] >= 8'd12);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_empty(string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " count"}, 32'(count), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " fields"}, {opcode, writeReg, readReg1, readReg2}, 32'h0);
    chk({tag, " immediate"}, immediate, 32'h0);
    chk({tag, " illegal"}, 32'(illegal), 32'd0);
  endtask

  function automatic logic [31:0] sw(int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, 8'h10 + b, 8'h20 + b, 8'h80 + b};
  endfunction

  initial begin
    logic [31:0] w [5];
    w[0] = 32'h0A000001; w[1] = 32'h0B000002; w[2] = 32'h03000003;
    w[3] = 32'h04000004; w[4] = 32'h05000005;

    // Single split and extension.
    tv.push_back(mk(1, 32'h12345678, 0, 0, 1, 32'h12345678));
    tv.push_back(mk(0, 32'h0,        0, 0, 1, 32'h12345678)); // held stable
    tv.push_back(mk(0, 32'h0,        1, 0, 0, 32'h0));
    tv.push_back(mk(1, 32'h020100F6, 0, 0, 1, 32'h020100F6));
    tv.push_back(mk(0, 32'h0,        1, 0, 0, 32'h0));
    // Fill to full; fifth word dropped, also when offered alongside a pop.
    tv.push_back(mk(1, w[0], 0, 0, 1, w[0]));
    tv.push_back(mk(1, w[1], 0, 0, 2, w[0]));
    tv.push_back(mk(1, w[2], 0, 0, 3, w[0]));
    tv.push_back(mk(1, w[3], 0, 0, 4, w[0]));
    tv.push_back(mk(1, w[4], 0, 0, 4, w[0]));
    tv.push_back(mk(1, w[4], 1, 0, 3, w[1]));
    tv.push_back(mk(0, 32'h0, 1, 0, 2, w[2]));
    tv.push_back(mk(0, 32'h0, 1, 0, 1, w[3]));
    tv.push_back(mk(0, 32'h0, 1, 0, 0, 32'h0));
    // Streaming push+pop across pointer wrap.
    for (int i = 0; i < 10; i++) tv.push_back(mk(1, sw(i), 1, 0, 1, sw(i)));
    tv.push_back(mk(0, 32'h0, 1, 0, 0, 32'h0));
    // Flush beats simultaneous push and pop.
    tv.push_back(mk(1, 32'h01000011, 0, 0, 1, 32'h01000011));
    tv.push_back(mk(1, 32'h02000022, 0, 0, 2, 32'h01000011));
    tv.push_back(mk(1, 32'h03000033, 0, 0, 3, 32'h01000011));
    tv.push_back(mk(1, 32'h04000044, 1, 1, 0, 32'h0));
    tv.push_back(mk(0, 32'h0,        0, 0, 0, 32'h0));
    tv.push_back(mk(1, 32'h05000055, 0, 0, 1, 32'h05000055));
    tv.push_back(mk(0, 32'h0,        1, 0, 0, 32'h0));

    RESET = 1'b1; FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0;
    #1;
    chk_empty("reset");
    #6 RESET = 1'b0;

    foreach (tv[k]) begin
      string n;
      n = $sformatf("v%0d", k);
      in_valid = tv[k].vin; in_instr = tv[k].instr;
      out_ready = tv[k].ordy; FLUSH = tv[k].flush;
      @(posedge CLK); #1;
      chk({n, " out_valid"}, 32'(out_valid), 32'(tv[k].ov));
      chk({n, " in_ready"}, 32'(in_ready), 32'(tv[k].ir));
      chk({n, " count"}, 32'(count), 32'(tv[k].cnt));
      chk({n, " fields"}, {opcode, writeReg, readReg1, readReg2}, tv[k].head);
      chk({n, " immediate"}, immediate, tv[k].imm);
      chk({n, " zext_immediate"}, z_immediate, tv[k].imm0);
      chk({n, " illegal"}, 32'(illegal), 32'(tv[k].ill));
    end

    // Asynchronous reset with two entries queued.
    FLUSH = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h01AA0001;
    @(posedge CLK); #1;
    in_instr = 32'h02BB0002;
    @(posedge CLK); #1;
    chk("pre_reset count", 32'(count), 32'd2);
    chk("pre_reset head", {opcode, writeReg, readReg1, readReg2}, 32'h01AA0001);
    in_valid = 1'b0;
    #2 RESET = 1'b1;
    #1 chk_empty("async_reset");
    #1 RESET = 1'b0;
    #1 chk_empty("after_reset");
    @(posedge CLK); #1;
    chk_empty("post_reset_idle");
    in_valid = 1'b1; in_instr = 32'h03CC00FF;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("resume count", 32'(count), 32'd1);
    chk("resume head", {opcode, writeReg, readReg1, readReg2}, 32'h03CC00FF);
    chk("resume immediate", immediate, 32'hFFFFFFFF);
    chk("resume zext_immediate", z_immediate, 32'h000000FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
